rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Write-back arbiter that sits directly upstream of the register file write port (wen/waddr/wdata).
- Merges two independent result producers into the single write port: source A (ALU/execute) and source B (load/long-latency unit).
- Each source has a valid/ready input, a 2-entry buffer and round-robin arbitration.
- Drives registered write outputs and a pending flag, which downstream hazard logic uses to stall operand reads.

Parameters:
- ADDR_WIDTH, 5, width of register address; matches register file address width.
- DATA_WIDTH, 32, width of write data; matches register file data width.
- DISCARD_ZERO, 1, when 1 a write to address 0 is consumed but never asserts wen.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  source A offers a result.
- a_ready  output  1  source A buffer can accept.
- a_addr  input  ADDR_WIDTH  source A destination register.
- a_data  input  DATA_WIDTH  source A result.
- b_valid  input  1  source B offers a result.
- b_ready  output  1  source B buffer can accept.
- b_addr  input  ADDR_WIDTH  source B destination register.
- b_data  input  DATA_WIDTH  source B result.
- wen  output  1  register file write enable (registered).
- waddr  output  ADDR_WIDTH  register file write address (registered).
- wdata  output  DATA_WIDTH  register file write data (registered).
- pending  output  1  any buffered entry or wen currently asserted.

Behaviour:
- Reset (async, rst_n=0):
  - Both buffers empty; wen=0, waddr=0, wdata=0.
  - Round-robin state = "B granted last", so A wins the first tie.
  - a_ready=b_ready=1 once reset is released; pending=0.
  - Reset mid-operation discards all buffered entries with no write.
- Handshake:
  - A transfer occurs on a rising edge where x_valid=1 and x_ready=1.
  - x_ready = (buffer count < 2). It depends only on the registered count, never on same-cycle pop; a full buffer shows ready=0 even in a cycle it is popped.
  - Data and address are captured at the transfer edge.
- Buffers:
  - Per source, 2-entry FIFO with in-order pop.
  - Simultaneous push and pop at count 1 keeps count 1, with order preserved.
  - Push at count 0 is never popped in the same cycle (no bypass).
- Arbitration, evaluated every cycle on buffer heads:
  - Neither buffer non-empty: no grant.
  - Exactly one non-empty: that source is granted.
  - Both non-empty: the source not granted last is granted.
  - The granted head is popped at the next edge, and round-robin state records the granted source.
- Output register, loaded at the same edge as the pop:
  - wen = 1 unless (DISCARD_ZERO=1 and head addr==0).
  - waddr/wdata = head fields.
  - No grant: wen=0; waddr/wdata hold their previous values.
  - A discarded address-0 entry still consumes the grant and updates round-robin state.
- Latency:
  - Transfer at edge E → earliest wen high in the cycle after edge E+1; that is, a handshake in cycle t gives wen in cycle t+2.
  - Sustained throughput is one write per cycle.
  - Under contention, each source gets at least one write every 2 cycles.
- pending = (countA != 0) | (countB != 0) | wen, combinational from registers.
- Ordering: writes from one source reach wen in acceptance order. No ordering is guaranteed between sources. Same-address conflicts across sources are the producers' responsibility.

Test Plan:
- Reset with both valids high → during reset wen=0, pending=0; first edge after release accepts both; A write in cycle t+2, B write in t+3.
- Single source A streams addr 1..8, data 0x100+addr, every cycle, with B idle → 8 consecutive wen cycles in order, no gaps after initial 2-cycle latency, a_ready never drops.
- Both sources continuously valid with distinct addrs → wen every cycle, grants strictly alternate A,B,A,B; each ready toggles pattern without loss or duplication.
- Source B: 3 pushes while A keeps the arbiter busy on alternate cycles → b_ready=0 when count=2; the third entry is held on b_valid until accepted; all three B writes appear in order.
- DISCARD_ZERO=1, A sends addr 0 data 0xDEAD then addr 3 data 0x3 → no wen for addr 0 in the expected cycle; next cycle wen=1, waddr=3, wdata=0x3. With DISCARD_ZERO=0 → wen=1, waddr=0, wdata=0xDEAD.
- Assert rst_n=0 asynchronously mid-cycle with 2 entries buffered per source → wen drops immediately; after release there are no writes from old entries, pending=0, and the next tie grants A.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Write-back arbiter in front of the register file write port.
// Two result producers are merged onto one registered write port:
//   source A (ALU / execute) and source B (load / long-latency unit).
// Each source has a 2-entry FIFO. The two FIFO heads are arbitrated round-robin.
//
// Ports
//   clk, rst_n                     clock and asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data  source A result handshake
//   b_valid/b_ready/b_addr/b_data  source B result handshake
//   wen/waddr/wdata                registered register-file write port
//   pending                        a buffered entry or an in-flight write exists;
//                                  hazard logic uses it to stall operand reads

// rf_wb_fifo2
// Two-entry in-order FIFO holding one {addr, data} result per entry.
// ready depends only on the registered count, so a full FIFO reports not-ready
// even in a cycle in which it is being popped.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   valid, ready          push handshake
//   addr, data            pushed fields
//   pop                   remove head (only asserted while not_empty)
//   not_empty             at least one entry held
//   head_addr, head_data  oldest entry
module rf_wb_fifo2 #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pop,
    output logic                  not_empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [ADDR_WIDTH-1:0] addr_mem [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  push;

    assign ready     = (count != 2'd2);
    assign push      = valid && ready;
    assign not_empty = (count != 2'd0);
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= addr;
            data_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

module rf_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int DISCARD_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  pending
);

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    localparam logic DISCARD = (DISCARD_ZERO != 0);

    last_t                 last_q;
    last_t                 last_d;
    logic                  grant_a;
    logic                  grant_b;
    logic                  a_ne;
    logic                  b_ne;
    logic [ADDR_WIDTH-1:0] a_head_addr;
    logic [DATA_WIDTH-1:0] a_head_data;
    logic [ADDR_WIDTH-1:0] b_head_addr;
    logic [DATA_WIDTH-1:0] b_head_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rf_wb_fifo2 #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (a_valid),
        .ready     (a_ready),
        .addr      (a_addr),
        .data      (a_data),
        .pop       (grant_a),
        .not_empty (a_ne),
        .head_addr (a_head_addr),
        .head_data (a_head_data)
    );

    rf_wb_fifo2 #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (b_valid),
        .ready     (b_ready),
        .addr      (b_addr),
        .data      (b_data),
        .pop       (grant_b),
        .not_empty (b_ne),
        .head_addr (b_head_addr),
        .head_data (b_head_data)
    );

    // Round-robin state resets to "B granted last" so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant_a) begin
            last_d = LAST_A;
        end else if (grant_b) begin
            last_d = LAST_B;
        end
    end

    // A lone non-empty source always wins; on a tie the source not granted last wins.
    always_comb begin
        grant_a = a_ne && (!b_ne || (last_q == LAST_B));
        grant_b = b_ne && !grant_a;
    end

    assign sel_addr = grant_a ? a_head_addr : b_head_addr;
    assign sel_data = grant_a ? a_head_data : b_head_data;

    // A granted address-0 entry is still consumed and still loads waddr/wdata;
    // only the enable is suppressed when discarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (grant_a || grant_b) begin
            wen   <= !(DISCARD && (sel_addr == '0));
            waddr <= sel_addr;
            wdata <= sel_data;
        end else begin
            wen <= 1'b0;
        end
    end

    assign pending = a_ne || b_ne || wen;

endmodule
